scalar_mult_ctrl: RTL

Sequencer for ECC scalar multiplication Q = k·P over GF(p), using the existing point-addition unit as its only arithmetic resource. Left-to-right double-and-add over the scalar bits. Restarts the point unit per operation through its reset, presents operands, waits for result/infinity, captures the sum, and tracks the point at infinity itself. Sits between the top-level ECC request interface and a single `point_addition` instance.

---
 rtl/ecc_pkg.sv | 25 ++
 rtl/scalar_mult_ctrl_if.sv | 40 ++++
 rtl/bit_scanner.sv | 48 ++++
 rtl/scalar_mult_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared types and defaults for the ECC scalar multiplier.
// State encoding, default widths and point-op timeout.
package ecc_pkg;

  localparam int ECC_N_DEF       = 10;
  localparam int ECC_K_DEF       = 10;
  localparam int ECC_TIMEOUT_DEF = 1023;

  typedef enum logic [3:0] {
    ECC_S_IDLE     = 4'd0,
    ECC_S_SCAN     = 4'd1,
    ECC_S_DBL_GO   = 4'd2,
    ECC_S_DBL_WAIT = 4'd3,
    ECC_S_DBL_CAP  = 4'd4,
    ECC_S_ADD_GO   = 4'd5,
    ECC_S_ADD_WAIT = 4'd6,
    ECC_S_ADD_CAP  = 4'd7,
    ECC_S_FIN      = 4'd8
  } ecc_state_e;

  function automatic int ecc_idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/scalar_mult_ctrl_if.sv
// Request/response bundle of the scalar multiplier.
// err exists only with SCALAR_MULT_TIMEOUT_EN.
interface scalar_mult_ctrl_if
  import ecc_pkg::*;
#(
  parameter int N = ECC_N_DEF,
  parameter int K = ECC_K_DEF
);

  logic         start;
  logic [K-1:0] k;
  logic [N-1:0] p;
  logic [N-1:0] xp;
  logic [N-1:0] yp;
  logic         busy;
  logic         done;
  logic [N-1:0] x_out;
  logic [N-1:0] y_out;
  logic         inf_out;
`ifdef SCALAR_MULT_TIMEOUT_EN
  logic         err;
`endif

  modport master (
    output start, k, p, xp, yp,
`ifdef SCALAR_MULT_TIMEOUT_EN
    input  err,
`endif
    input  busy, done, x_out, y_out, inf_out
  );

  modport slave (
    input  start, k, p, xp, yp,
`ifdef SCALAR_MULT_TIMEOUT_EN
    output err,
`endif
    output busy, done, x_out, y_out, inf_out
  );

endinterface

// File: rtl/bit_scanner.sv
// Holds the latched scalar and walks its bits MSB first.
// cur_bit is k[i]; last flags i == 0.
module bit_scanner
  import ecc_pkg::*;
#(
  parameter int K = ECC_K_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [K-1:0] k_in,
  output logic         cur_bit,
  output logic         last
);

  localparam int IW = ecc_idx_w(K);

  logic [K-1:0]  k_q, k_d;
  logic [IW-1:0] i_q, i_d;

  // load restarts at the MSB, dec steps one bit down
  always_comb begin
    k_d = k_q;
    i_d = i_q;
    if (load) begin
      k_d = k_in;
      i_d = IW'(K - 1);
    end else if (dec && (i_q != '0)) begin
      i_d = i_q - 1'b1;
    end
  end

  // scalar and index registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      i_q <= i_d;
    end
  end

  assign cur_bit = k_q[i_q];
  assign last    = (i_q == '0);

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Double-and-add sequencer driving one point-addition unit.
// Optional op timeout: define SCALAR_MULT_TIMEOUT_EN.
module scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int N       = ECC_N_DEF,
  parameter int K       = ECC_K_DEF,
  parameter int TIMEOUT = ECC_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  scalar_mult_ctrl_if.slave req,
  output logic              pa_reset,
  output logic [N-1:0]      pa_p,
  output logic [N-1:0]      pa_x1,
  output logic [N-1:0]      pa_y1,
  output logic [N-1:0]      pa_x2,
  output logic [N-1:0]      pa_y2,
  input  logic [N-1:0]      pa_x3,
  input  logic [N-1:0]      pa_y3,
  input  logic              pa_result,
  input  logic              pa_infinity
);

  ecc_state_e state_q, state_d;

  logic [N-1:0] p_q, p_d;
  logic [N-1:0] xp_q, xp_d;
  logic [N-1:0] yp_q, yp_d;
  logic [N-1:0] qx_q, qx_d;
  logic [N-1:0] qy_q, qy_d;
  logic         qinf_q, qinf_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] x_out_q, x_out_d;
  logic [N-1:0] y_out_q, y_out_d;
  logic         inf_out_q, inf_out_d;
  logic         pa_reset_q, pa_reset_d;
  logic [N-1:0] pa_x1_q, pa_x1_d;
  logic [N-1:0] pa_y1_q, pa_y1_d;
  logic [N-1:0] pa_x2_q, pa_x2_d;
  logic [N-1:0] pa_y2_q, pa_y2_d;

  logic sc_load;
  logic sc_dec;
  logic sc_bit;
  logic sc_last;
  logic go_next;
  logic abort;
  logic tmo;
  logic pa_fin;

  assign pa_fin = pa_result | pa_infinity;

  bit_scanner #(.K(K)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .load    (sc_load),
    .dec     (sc_dec),
    .k_in    (req.k),
    .cur_bit (sc_bit),
    .last    (sc_last)
  );

`ifdef SCALAR_MULT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign tmo = (cnt_q == TW'(TIMEOUT - 1));

  // per-op wait counter and sticky abort flag
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if ((state_q == ECC_S_DBL_WAIT) ||
        (state_q == ECC_S_ADD_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
      if (!pa_fin && tmo) err_d = 1'b1;
    end
    if ((state_q == ECC_S_IDLE) && req.start)
      err_d = 1'b0;
  end

  // timeout registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign req.err = err_q;
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign unused_tmo = ^TIMEOUT;
`endif

  // next state, accumulator and unit operands
  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    xp_d       = xp_q;
    yp_d       = yp_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    qinf_d     = qinf_q;
    done_d     = 1'b0;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    inf_out_d  = inf_out_q;
    pa_x1_d    = pa_x1_q;
    pa_y1_d    = pa_y1_q;
    pa_x2_d    = pa_x2_q;
    pa_y2_d    = pa_y2_q;
    sc_load    = 1'b0;
    sc_dec     = 1'b0;
    go_next    = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      ECC_S_IDLE: begin
        if (req.start) begin
          p_d     = req.p;
          xp_d    = req.xp;
          yp_d    = req.yp;
          qinf_d  = 1'b1;
          sc_load = 1'b1;
          state_d = ECC_S_SCAN;
        end
      end
      ECC_S_SCAN: begin
        if (!qinf_q) begin
          state_d = ECC_S_DBL_GO;
        end else begin
          if (sc_bit) begin
            qx_d   = xp_q;
            qy_d   = yp_q;
            qinf_d = 1'b0;
          end
          go_next = 1'b1;
        end
      end
      ECC_S_DBL_GO: state_d = ECC_S_DBL_WAIT;
      ECC_S_DBL_WAIT: begin
        if (pa_fin) state_d = ECC_S_DBL_CAP;
        else if (tmo) abort = 1'b1;
      end
      ECC_S_DBL_CAP: begin
        if (pa_infinity) begin
          qinf_d = 1'b1;
        end else begin
          qx_d = pa_x3;
          qy_d = pa_y3;
        end
        if (sc_bit && !pa_infinity) begin
          state_d = ECC_S_ADD_GO;
        end else begin
          if (sc_bit) begin
            qx_d   = xp_q;
            qy_d   = yp_q;
            qinf_d = 1'b0;
          end
          go_next = 1'b1;
        end
      end
      ECC_S_ADD_GO: state_d = ECC_S_ADD_WAIT;
      ECC_S_ADD_WAIT: begin
        if (pa_fin) state_d = ECC_S_ADD_CAP;
        else if (tmo) abort = 1'b1;
      end
      ECC_S_ADD_CAP: begin
        if (pa_infinity) begin
          qinf_d = 1'b1;
        end else begin
          qx_d = pa_x3;
          qy_d = pa_y3;
        end
        go_next = 1'b1;
      end
      ECC_S_FIN: begin
        x_out_d   = qinf_q ? '0 : qx_q;
        y_out_d   = qinf_q ? '0 : qy_q;
        inf_out_d = qinf_q;
        done_d    = 1'b1;
        state_d   = ECC_S_IDLE;
      end
      default: state_d = ECC_S_IDLE;
    endcase

    if (go_next) begin
      if (sc_last) begin
        state_d = ECC_S_FIN;
      end else begin
        sc_dec  = 1'b1;
        state_d = ECC_S_SCAN;
      end
    end

    if (abort) begin
      x_out_d   = '0;
      y_out_d   = '0;
      inf_out_d = 1'b1;
      done_d    = 1'b1;
      state_d   = ECC_S_IDLE;
    end

    if (state_d == ECC_S_DBL_GO) begin
      pa_x1_d = qx_d;
      pa_y1_d = qy_d;
      pa_x2_d = qx_d;
      pa_y2_d = qy_d;
    end else if (state_d == ECC_S_ADD_GO) begin
      pa_x1_d = qx_d;
      pa_y1_d = qy_d;
      pa_x2_d = xp_q;
      pa_y2_d = yp_q;
    end
  end

  // unit runs only while waiting; held in reset otherwise
  always_comb begin
    pa_reset_d = !((state_d == ECC_S_DBL_WAIT) ||
                   (state_d == ECC_S_ADD_WAIT));
    busy_d     = (state_d != ECC_S_IDLE);
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ECC_S_IDLE;
      p_q        <= '0;
      xp_q       <= '0;
      yp_q       <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      qinf_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_out_q    <= '0;
      y_out_q    <= '0;
      inf_out_q  <= 1'b1;
      pa_reset_q <= 1'b1;
      pa_x1_q    <= '0;
      pa_y1_q    <= '0;
      pa_x2_q    <= '0;
      pa_y2_q    <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      xp_q       <= xp_d;
      yp_q       <= yp_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      qinf_q     <= qinf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      inf_out_q  <= inf_out_d;
      pa_reset_q <= pa_reset_d;
      pa_x1_q    <= pa_x1_d;
      pa_y1_q    <= pa_y1_d;
      pa_x2_q    <= pa_x2_d;
      pa_y2_q    <= pa_y2_d;
    end
  end

  assign req.busy    = busy_q;
  assign req.done    = done_q;
  assign req.x_out   = x_out_q;
  assign req.y_out   = y_out_q;
  assign req.inf_out = inf_out_q;
  assign pa_reset    = pa_reset_q;
  assign pa_p        = p_q;
  assign pa_x1       = pa_x1_q;
  assign pa_y1       = pa_y1_q;
  assign pa_x2       = pa_x2_q;
  assign pa_y2       = pa_y2_q;

endmodule
